// File: rtl/bcd_to_bin.sv
// bcd_to_bin: sequential packed-BCD to binary converter (reverse double-dabble).
// One bit moves from the digit register into the binary register per cycle;
// digits that land at >= 8 after the shift are pulled back by 3.

// Per-digit correction applied after each right shift.
module bcd_to_bin_digit (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd8) ? d - 4'd3 : d;
endmodule

module bcd_to_bin #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    data_out,
  output logic                err
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(W+1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   dig, bin, dig_nxt, bin_nxt;
  logic [W-1:0]   dig_sh, bin_sh, dig_fix;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [BIN_W-1:0] data_nxt;
  logic           err_nxt;
  logic           bad;

  // One-bit right shift of the {digit, binary} pair; digit LSB feeds binary MSB.
  assign {dig_sh, bin_sh} = {dig, bin} >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_to_bin_digit u_dig (.d(dig_sh[4*g +: 4]), .q(dig_fix[4*g +: 4]));
  end

  // Flag any input nibble outside 0..9.
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (bcd_in[4*i +: 4] > 4'd9) bad = 1'b1;
  end

  assign busy = (state == CONV);
  assign done = (state == DONE);

  // Next-state and datapath; DONE accepts start exactly like IDLE.
  always_comb begin
    state_nxt = state;
    dig_nxt   = dig;
    bin_nxt   = bin;
    cnt_nxt   = cnt;
    data_nxt  = data_out;
    err_nxt   = err;
    case (state)
      IDLE, DONE: begin
        state_nxt = IDLE;
        if (start) begin
          dig_nxt = bcd_in;
          bin_nxt = '0;
          cnt_nxt = CW'(W);
          if (bad) begin
            state_nxt = DONE;
            data_nxt  = '0;
            err_nxt   = 1'b1;
          end else begin
            state_nxt = CONV;
          end
        end
      end
      CONV: begin
        dig_nxt = dig_fix;
        bin_nxt = bin_sh;
        cnt_nxt = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          state_nxt = DONE;
          data_nxt  = bin_sh[BIN_W-1:0];
          err_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      dig      <= '0;
      bin      <= '0;
      cnt      <= '0;
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      dig      <= dig_nxt;
      bin      <= bin_nxt;
      cnt      <= cnt_nxt;
      data_out <= data_nxt;
      err      <= err_nxt;
    end
  end
endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: 2-digit instance for handshake/latency
// scenarios, 3-digit instance for a full valid sweep and invalid nibbles.
module tb_bcd_to_bin;
  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       start = 1'b0;
  logic [7:0] bcd = '0;
  logic       busy, done, err;
  logic [6:0] dout;

  logic        start3 = 1'b0;
  logic [11:0] bcd3 = '0;
  logic        busy3, done3, err3;
  logic [9:0]  dout3;

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  bcd_to_bin #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd),
    .busy(busy), .done(done), .data_out(dout), .err(err));

  bcd_to_bin #(.DIGITS(3), .BIN_W(10)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .bcd_in(bcd3),
    .busy(busy3), .done(done3), .data_out(dout3), .err(err3));

  // One conversion on the 2-digit instance; lat counts edges from the drive
  // edge to the cycle done is seen (-1 on timeout).
  task automatic run2(input logic [7:0] b, output logic [6:0] v, output logic e,
                      output int lat, output int bn, output int extra);
    v = '0; e = 1'b0; lat = -1; bn = 0; extra = 0;
    @(negedge clk); start = 1'b1; bcd = b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) bn++;
      if (done) begin lat = i; v = dout; e = err; break; end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
  endtask

  task automatic run3(input logic [11:0] b, output logic [9:0] v, output logic e,
                      output int lat);
    v = '0; e = 1'b0; lat = -1;
    @(negedge clk); start3 = 1'b1; bcd3 = b;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start3 = 1'b0;
      if (done3) begin lat = i; v = dout3; e = err3; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, err, dout} !== 10'd0) begin
      errors++; $display("FAIL reset2: busy/done/err/dout=%b/%b/%b/%0d exp 0", busy, done, err, dout);
    end
    checks++;
    if ({busy3, done3, err3, dout3} !== 13'd0) begin
      errors++; $display("FAIL reset3: busy/done/err/dout=%b/%b/%b/%0d exp 0", busy3, done3, err3, dout3);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [6:0] v; logic e; int lat, bn, extra;
    logic [7:0] vin [3] = '{8'h42, 8'h00, 8'h10};
    int         vexp[3] = '{42, 0, 10};
    run2(8'h99, v, e, lat, bn, extra);
    checks++; if (v !== 7'h63) begin errors++; $display("FAIL conv99 data: got %0d exp 99", v); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL conv99 err: got %b exp 0", e); end
    checks++; if (lat != 9) begin errors++; $display("FAIL conv99 latency: got %0d exp 9", lat); end
    checks++; if (bn != 8) begin errors++; $display("FAIL conv99 busy cycles: got %0d exp 8", bn); end
    checks++; if (extra != 0) begin errors++; $display("FAIL conv99 done width: extra pulses %0d exp 0", extra); end
    checks++; if (dout !== 7'h63) begin errors++; $display("FAIL conv99 hold: got %0d exp 99", dout); end
    for (int i = 0; i < 3; i++) begin
      run2(vin[i], v, e, lat, bn, extra);
      checks++;
      if (v !== 7'(vexp[i]) || e !== 1'b0 || lat != 9) begin
        errors++; $display("FAIL conv %h: data=%0d err=%b lat=%0d exp %0d/0/9", vin[i], v, e, lat, vexp[i]);
      end
    end
  endtask

  task automatic test_invalid;
    logic [6:0] v; logic e; int lat, bn, extra;
    logic [7:0] bad [3] = '{8'hA3, 8'h3F, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      run2(bad[i], v, e, lat, bn, extra);
      checks++;
      if (e !== 1'b1 || v !== 7'd0 || lat != 1 || bn != 0) begin
        errors++; $display("FAIL invalid %h: err=%b data=%0d lat=%0d busy=%0d exp 1/0/1/0", bad[i], e, v, lat, bn);
      end
    end
    run2(8'h07, v, e, lat, bn, extra);
    checks++;
    if (e !== 1'b0 || v !== 7'd7 || lat != 9) begin
      errors++; $display("FAIL after invalid 07: err=%b data=%0d lat=%0d exp 0/7/9", e, v, lat);
    end
  endtask

  task automatic test_ignore_start;
    int nd = 0; logic [6:0] v = '0;
    @(negedge clk); start = 1'b1; bcd = 8'h31;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1; bcd = 8'h55;
    @(negedge clk); start = 1'b0; bcd = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin nd++; v = dout; end
    end
    checks++; if (nd != 1) begin errors++; $display("FAIL ignore start pulses: got %0d exp 1", nd); end
    checks++; if (v !== 7'd31) begin errors++; $display("FAIL ignore start data: got %0d exp 31", v); end
  endtask

  task automatic test_back_to_back;
    logic [6:0] v1 = '0; logic got1 = 1'b0; int lat2 = -1; logic b1 = 1'b0;
    @(negedge clk); start = 1'b1; bcd = 8'h64;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; bcd = 8'h12;
    for (int i = 0; i < 20; i++) begin
      if (done) begin got1 = 1'b1; v1 = dout; break; end
      @(negedge clk);
    end
    for (int j = 1; j <= 20; j++) begin
      @(negedge clk);
      if (j == 1) begin start = 1'b0; b1 = busy; end
      if (done) begin lat2 = j; break; end
    end
    checks++;
    if (got1 !== 1'b1 || v1 !== 7'd64) begin
      errors++; $display("FAIL b2b first: seen=%b data=%0d exp 1/64", got1, v1);
    end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL b2b restart busy: got %b exp 1", b1); end
    checks++;
    if (lat2 != 9 || dout !== 7'd12 || err !== 1'b0) begin
      errors++; $display("FAIL b2b second: lat=%0d data=%0d err=%b exp 9/12/0", lat2, dout, err);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int nd = 0; logic [6:0] v; logic e; int lat, bn, extra;
    @(negedge clk); start = 1'b1; bcd = 8'h77;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, err, dout} !== 10'd0) begin
      errors++; $display("FAIL reset mid: busy/done/err/dout=%b/%b/%b/%0d exp 0", busy, done, err, dout);
    end
    rst = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd != 0) begin errors++; $display("FAIL reset mid pulses: got %0d exp 0", nd); end
    run2(8'h59, v, e, lat, bn, extra);
    checks++;
    if (v !== 7'd59 || e !== 1'b0 || lat != 9) begin
      errors++; $display("FAIL after reset 59: data=%0d err=%b lat=%0d exp 59/0/9", v, e, lat);
    end
  endtask

  task automatic test_digits3;
    logic [9:0] v; logic e; int lat;
    logic [11:0] b;
    run3(12'h999, v, e, lat);
    checks++;
    if (v !== 10'd999 || e !== 1'b0 || lat != 13) begin
      errors++; $display("FAIL d3 999: data=%0d err=%b lat=%0d exp 999/0/13", v, e, lat);
    end
    for (int d2 = 0; d2 < 10; d2++)
      for (int d1 = 0; d1 < 10; d1++)
        for (int d0 = 0; d0 < 10; d0++) begin
          b = {4'(d2), 4'(d1), 4'(d0)};
          run3(b, v, e, lat);
          checks++;
          if (v !== 10'(d2*100 + d1*10 + d0) || e !== 1'b0) begin
            errors++; $display("FAIL d3 sweep %h: data=%0d err=%b exp %0d/0", b, v, e, d2*100 + d1*10 + d0);
          end
        end
    for (int p = 0; p < 3; p++)
      for (int n = 10; n < 16; n++) begin
        b = 12'h555;
        b[4*p +: 4] = 4'(n);
        run3(b, v, e, lat);
        checks++;
        if (e !== 1'b1 || v !== 10'd0 || lat != 1) begin
          errors++; $display("FAIL d3 invalid %h: err=%b data=%0d lat=%0d exp 1/0/1", b, e, v, lat);
        end
      end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_invalid;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid;
    test_digits3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
